// File: rtl/conv_frame_sched.sv
// conv_frame_sched
// Sequencer for the 2D convolution engine: loads an IMG x IMG pixel frame
// into the image RAM, issues every OUT x OUT window origin to the datapath,
// and steers the datapath results into the result store. One-cycle done
// pulse per completed frame.
//
// Handshake rule for every valid/ready pair on this block: a transfer
// happens in exactly the cycles where valid and ready are both high at the
// rising edge; valid-side data is held stable while valid is high and ready
// is low.
module conv_frame_sched #(
    parameter int IMG = 8,
    parameter int K   = 3,
    parameter int AW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [2:0]    win_row,
    output logic [2:0]    win_col,
    input  logic          res_valid,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state_dbg
);

    localparam int OUT = IMG - K + 1;

    localparam logic [AW-1:0] LAST_PIX = AW'(IMG * IMG - 1);
    localparam logic [AW-1:0] LAST_RES = AW'(OUT * OUT - 1);
    localparam logic [2:0]    LAST_RC  = 3'(OUT - 1);
    localparam logic [AW-1:0] ONE_AW   = AW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pix_cnt;
    logic [AW-1:0] res_cnt;
    logic [2:0]    row_q, col_q;

    logic          win_acc;
    logic          last_issue;
    logic          final_res;

    assign win_acc    = win_valid & win_ready;
    assign last_issue = win_acc & (row_q == LAST_RC) & (col_q == LAST_RC);
    assign final_res  = res_we & (res_cnt == LAST_RES);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and all strobes; strobes are pure decodes of state and inputs.
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        win_valid = 1'b0;
        res_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_cnt == LAST_PIX) state_nxt = RUN;
            end
            RUN: begin
                win_valid = 1'b1;
                res_we    = res_valid;
                // Final result can only coincide with the last issue here.
                if (res_valid && res_cnt == LAST_RES) state_nxt = DONE;
                else if (win_ready && row_q == LAST_RC && col_q == LAST_RC)
                    state_nxt = WAIT;
            end
            WAIT: begin
                res_we = res_valid;
                if (res_valid && res_cnt == LAST_RES) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_we    = pix_valid & pix_ready;
    assign ram_waddr = pix_cnt;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign res_addr  = res_cnt;
    assign state_dbg = state;

    // Pixel, window-origin and result counters; cleared on a new frame and
    // again on the way out so IDLE always shows zeroed addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt <= '0;
            res_cnt <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            if ((state == IDLE && start) || state == DONE) begin
                pix_cnt <= '0;
                res_cnt <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                if (ram_we) begin
                    // Last pixel parks the counter at 0 rather than spilling
                    // into a second frame.
                    if (pix_cnt == LAST_PIX) pix_cnt <= '0;
                    else                     pix_cnt <= pix_cnt + ONE_AW;
                end
                if (win_acc) begin
                    if (last_issue) begin
                        row_q <= '0;
                        col_q <= '0;
                    end else if (col_q == LAST_RC) begin
                        col_q <= '0;
                        row_q <= row_q + 3'd1;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                if (res_we && !final_res) res_cnt <= res_cnt + ONE_AW;
                else if (final_res)       res_cnt <= res_cnt + ONE_AW;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Directed bench for conv_frame_sched: full frames under several pixel,
// window and result timing patterns, ignored inputs, and reset mid-run.
module tb_conv_frame_sched;

  localparam int IMG = 8;
  localparam int K   = 3;
  localparam int AW  = 6;
  localparam int OUT = IMG - K + 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, pix_valid, win_ready, res_valid;
  logic          pix_ready, ram_we, win_valid, res_we, busy, done;
  logic [AW-1:0] ram_waddr, res_addr;
  logic [2:0]    win_row, win_col, state_dbg;

  conv_frame_sched #(.IMG(IMG), .K(K), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col),
    .res_valid(res_valid), .res_we(res_we), .res_addr(res_addr),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_waddr_q[$];
  logic [5:0]    exp_win_q[$];
  logic [AW-1:0] exp_res_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_ram_we"},    ram_we,    0);
    check({tag, "_ram_waddr"}, ram_waddr, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_row"},   win_row,   0);
    check({tag, "_win_col"},   win_col,   0);
    check({tag, "_res_we"},    res_we,    0);
    check({tag, "_res_addr"},  res_addr,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  task automatic load_expected();
    exp_waddr_q.delete();
    exp_win_q.delete();
    exp_res_q.delete();
    for (int i = 0; i < IMG * IMG; i++) exp_waddr_q.push_back(AW'(i));
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++) exp_win_q.push_back({3'(r), 3'(c)});
    for (int i = 0; i < OUT * OUT; i++) exp_res_q.push_back(AW'(i));
  endtask

  // driver: one frame. pmode 0 = pixels every cycle, 1 = every other cycle.
  // wmode 0 = win_ready always, 1 = low every third cycle. lat = result
  // latency after accept (0 = same cycle, 2 = two cycles). inj = pulse start
  // and res_valid where they must be ignored. abort_n > 0 = reset after that
  // many window issues.
  task automatic run_frame(input int pmode, input int wmode, input int lat,
                           input bit inj, input int abort_n);
    int cyc, n_wr, n_iss, n_res, n_done, last_res_cyc, stalls, post;
    bit saw_wait, was_stall, finished, aborted;
    logic [2:0] held_r, held_c;
    int res_due[$];
    cyc = 0; n_wr = 0; n_iss = 0; n_res = 0; n_done = 0;
    last_res_cyc = -10; stalls = 0; post = 0;
    saw_wait = 0; was_stall = 0; finished = 0; aborted = 0;
    held_r = '0; held_c = '0;
    load_expected();
    while (!finished) begin
      @(negedge clk);
      start     = (cyc == 0) || (inj && (cyc == 10 || cyc == 80));
      pix_valid = (pmode == 0) ? 1'b1 : (cyc % 2 == 0);
      win_ready = (wmode == 0) ? 1'b1 : (cyc % 3 != 2);
      if (lat == 0) begin
        res_valid = win_valid & win_ready;
      end else begin
        res_valid = 1'b0;
        if (res_due.size() > 0 && res_due[0] == cyc) begin
          res_valid = 1'b1;
          void'(res_due.pop_front());
        end
      end
      if (inj && (cyc == 0 || cyc == 5)) res_valid = 1'b1;
      #1;
      if (state_dbg == ST_WAIT) saw_wait = 1;
      if (inj && (cyc == 0 || cyc == 5)) begin
        check("ignored_res_we", res_we, 0);
        check("ignored_res_addr", res_addr, 0);
      end
      if (ram_we) begin
        n_wr++;
        if (exp_waddr_q.size() > 0) check("ram_waddr", ram_waddr, exp_waddr_q.pop_front());
        else check("ram_we_extra", ram_we, 0);
      end
      if (was_stall) begin
        stalls++;
        check("stall_row", win_row, held_r);
        check("stall_col", win_col, held_c);
      end
      was_stall = win_valid && !win_ready;
      held_r = win_row;
      held_c = win_col;
      if (win_valid && win_ready) begin
        n_iss++;
        if (exp_win_q.size() > 0) check("win_origin", {win_row, win_col}, exp_win_q.pop_front());
        else check("win_extra", win_valid, 0);
        if (lat != 0) res_due.push_back(cyc + lat);
      end
      if (res_we) begin
        n_res++;
        last_res_cyc = cyc;
        if (exp_res_q.size() > 0) check("res_addr", res_addr, exp_res_q.pop_front());
        else check("res_we_extra", res_we, 0);
      end
      if (done) begin
        n_done++;
        check("done_latency", cyc - last_res_cyc, 1);
        check("busy_in_done", busy, 1);
      end
      if (n_done > 0) begin
        post++;
        if (post == 2) begin
          check("busy_after_done", busy, 0);
          check("idle_after_done", state_dbg, ST_IDLE);
          finished = 1;
        end
      end
      if (abort_n > 0 && n_iss == abort_n && !aborted) begin
        aborted = 1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        res_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        reset = 1'b1;
        finished = 1;
      end
      cyc++;
      if (!finished && cyc > 600) begin
        check("frame_timeout", 0, 1);
        finished = 1;
      end
    end
    if (!aborted) begin
      check("n_writes", n_wr, IMG * IMG);
      check("n_issues", n_iss, OUT * OUT);
      check("n_results", n_res, OUT * OUT);
      check("n_done", n_done, 1);
      check("wait_visited", saw_wait, (lat != 0) ? 1 : 0);
      if (wmode != 0) check("stalls_seen", (stalls > 0) ? 1 : 0, 1);
    end else begin
      check("abort_issue_count", n_iss, abort_n);
    end
    start = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_frame(0, 0, 2, 1'b0, 0);   // basic frame
    repeat (2) @(negedge clk);
    run_frame(1, 1, 2, 1'b0, 0);   // pixel gaps and window backpressure
    repeat (2) @(negedge clk);
    run_frame(0, 0, 0, 1'b0, 0);   // zero-latency datapath, WAIT skipped
    repeat (2) @(negedge clk);
    run_frame(0, 0, 2, 1'b1, 0);   // ignored start / res_valid
    repeat (2) @(negedge clk);
    run_frame(0, 0, 2, 1'b0, 20);  // reset after 20 issues
    @(negedge clk);
    #1;
    check("post_reset_idle", state_dbg, ST_IDLE);
    run_frame(0, 0, 2, 1'b0, 0);   // full frame after the abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
